// File: rtl/wb_pkg.sv
// Shared constants and payload type for the write-back scoreboard.
// XLEN  : result / write-port data width
// REG_W : register index width (RV32E, 16 registers)
// NREG  : number of architectural registers
package wb_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 4;
    localparam int unsigned NREG  = 16;

    // One pending write-back: destination register plus result data.
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_req_t entries holding LSU results until the write port is free.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (empties the FIFO)
//   push_i, wdata_i : enqueue an entry (ignored when full)
//   pop_i, rdata_o  : dequeue the head entry (ignored when empty); rdata_o shows the head
//   full_o, empty_o : occupancy flags
//   count_o         : number of stored entries
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  wb_req_t                    wdata_i,
    input  logic                       pop_i,
    output wb_req_t                    rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_req_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is data-path only; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Write-back initiator for the RV32E register file: arbitrates ALU results (priority)
// and queued LSU results onto the single register-file write port, and keeps a busy
// scoreboard of registers awaiting a load result.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   issue_valid/issue_long/issue_rd  : issuing instruction; loads mark issue_rd busy
//   rs1, rs2                         : sources of the instruction considered for issue
//   hazard                           : combinational RAW/WAW hazard indication
//   busy                             : scoreboard bits (bit 0 always 0)
//   alu_valid/alu_rd/alu_data        : single-cycle ALU result, no backpressure
//   lsu_valid/lsu_ready/lsu_rd/lsu_data : LSU result handshake into the FIFO
//   we/rd/rd_data                    : registered register-file write port
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int unsigned LSU_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              issue_long,
    input  logic [REG_W-1:0]  issue_rd,
    input  logic [REG_W-1:0]  rs1,
    input  logic [REG_W-1:0]  rs2,
    output logic              hazard,
    output logic [NREG-1:0]   busy,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_W-1:0]  lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              we,
    output logic [REG_W-1:0]  rd,
    output logic [XLEN-1:0]   rd_data
);

    localparam int unsigned CNT_W = $clog2(LSU_DEPTH) + 1;

    wb_req_t             fifo_wdata;
    wb_req_t             fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_push;
    logic                fifo_pop;

    logic                we_q,      we_d;
    logic [REG_W-1:0]    rd_q,      rd_d;
    logic [XLEN-1:0]     rd_data_q, rd_data_d;
    logic [NREG-1:0]     busy_q,    busy_d;

    // Ready drops during reset and whenever the FIFO is full, even if a pop is under way.
    assign lsu_ready  = ~rst & (fifo_count < CNT_W'(LSU_DEPTH));
    assign fifo_push  = lsu_valid & lsu_ready & ~fifo_full;
    // The ALU always wins the write port; the FIFO drains only on idle ALU cycles.
    assign fifo_pop   = ~alu_valid & ~fifo_empty;
    assign fifo_wdata = '{rd: lsu_rd, data: lsu_data};

    wb_fifo #(
        .DEPTH (LSU_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign hazard  = busy_q[rs1] | busy_q[rs2] | busy_q[issue_rd];
    assign busy    = busy_q;
    assign we      = we_q;
    assign rd      = rd_q;
    assign rd_data = rd_data_q;

    // Write-port arbitration; x0 targets are consumed but never written.
    always_comb begin
        we_d      = 1'b0;
        rd_d      = rd_q;
        rd_data_d = rd_data_q;
        if (alu_valid) begin
            we_d      = (alu_rd != '0);
            rd_d      = alu_rd;
            rd_data_d = alu_data;
        end else if (fifo_pop) begin
            we_d      = (fifo_head.rd != '0);
            rd_d      = fifo_head.rd;
            rd_data_d = fifo_head.data;
        end
    end

    // Scoreboard: clear on LSU pop, then set on load issue so a same-index set wins.
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop) begin
            busy_d[fifo_head.rd] = 1'b0;
        end
        if (issue_valid && issue_long && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            rd_q      <= '0;
            rd_data_q <= '0;
            busy_q    <= '0;
        end else begin
            we_q      <= we_d;
            rd_q      <= rd_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed self-checking bench for wb_scoreboard.
// Inputs change 1 ns after a rising edge; registered outputs are checked at the same
// point, so a value driven before tick() is seen in the outputs after tick().
module tb_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_long;
    logic [3:0]  issue_rd, rs1, rs2;
    logic        hazard;
    logic [15:0] busy;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [3:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        we;
    logic [3:0]  rd;
    logic [31:0] rd_data;

    int total = 0;
    int bad   = 0;

    wb_scoreboard #(.LSU_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .hazard(hazard), .busy(busy),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .we(we), .rd(rd), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic exp_we, input logic [3:0] exp_rd,
                          input logic [31:0] exp_data);
        chk({tag, ".we"}, 32'(we), 32'(exp_we));
        if (exp_we) begin
            chk({tag, ".rd"}, 32'(rd), 32'(exp_rd));
            chk({tag, ".data"}, rd_data, exp_data);
        end
    endtask

    // Issue logic never lets the ALU write a register with a pending load.
    always @(negedge clk) begin
        if (!rst && alu_valid && busy[alu_rd]) begin
            chk("alu_to_busy", 32'(busy[alu_rd]), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout got running want finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        issue_valid = 0; issue_long = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        tick(); tick();

        // Reset state
        chk("rst.we", 32'(we), 0);
        chk("rst.rd", 32'(rd), 0);
        chk("rst.data", rd_data, 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.ready", 32'(lsu_ready), 0);
        rst = 1'b0;
        #1 chk("post_rst.ready", 32'(lsu_ready), 1);
        tick();

        // ALU write: one cycle latency, one cycle only
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        tick();
        chk_wr("alu", 1, 5, 32'hDEADBEEF);
        alu_valid = 0;
        tick();
        chk("alu_after.we", 32'(we), 0);
        chk("alu_after.rd_hold", 32'(rd), 5);
        chk("alu_after.data_hold", rd_data, 32'hDEADBEEF);

        // Load scoreboard on x7
        issue_valid = 1; issue_long = 1; issue_rd = 7;
        #1 chk("ld.hazard_pre", 32'(hazard), 0);
        tick();
        issue_valid = 0; issue_long = 0; issue_rd = 0;
        chk("ld.busy_set", 32'(busy), 32'h0080);
        rs1 = 7;
        #1 chk("ld.hazard_rs1", 32'(hazard), 1);
        rs1 = 0; rs2 = 7;
        #1 chk("ld.hazard_rs2", 32'(hazard), 1);
        rs2 = 0;
        #1 chk("ld.hazard_clr", 32'(hazard), 0);
        tick(); tick(); tick(); tick();
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h00001234;
        #1 chk("ld.ready", 32'(lsu_ready), 1);
        tick();
        lsu_valid = 0;
        chk("ld.no_bypass", 32'(we), 0);
        chk("ld.busy_hold", 32'(busy), 32'h0080);
        tick();
        chk_wr("ld.write", 1, 7, 32'h00001234);
        chk("ld.busy_clr", 32'(busy), 0);

        // Contention: ALU owns the port, LSU results drain afterwards in order
        alu_valid = 1; alu_rd = 1; alu_data = 32'hA1;
        lsu_valid = 1; lsu_rd = 8; lsu_data = 32'h80;
        tick();
        chk_wr("cont.x1", 1, 1, 32'hA1);
        alu_rd = 2; alu_data = 32'hA2; lsu_rd = 9; lsu_data = 32'h90;
        tick();
        chk_wr("cont.x2", 1, 2, 32'hA2);
        alu_rd = 3; alu_data = 32'hA3; lsu_valid = 0;
        tick();
        chk_wr("cont.x3", 1, 3, 32'hA3);
        alu_valid = 0;
        tick();
        chk_wr("cont.x8", 1, 8, 32'h80);
        tick();
        chk_wr("cont.x9", 1, 9, 32'h90);
        tick();
        chk("cont.idle", 32'(we), 0);

        // Full FIFO: four accepted under continuous ALU, fifth held until a pop
        alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
        for (int i = 0; i < 4; i++) begin
            lsu_valid = 1; lsu_rd = 4'(10 + i); lsu_data = 32'(32'h100 + i);
            #1 chk("full.ready_acc", 32'(lsu_ready), 1);
            tick();
        end
        lsu_rd = 14; lsu_data = 32'h104;
        chk("full.ready_lo", 32'(lsu_ready), 0);
        tick();
        chk("full.ready_still_lo", 32'(lsu_ready), 0);
        chk_wr("full.alu", 1, 1, 32'h11);
        alu_valid = 0;
        #1 chk("full.no_push_on_pop", 32'(lsu_ready), 0);
        tick();
        chk_wr("full.x10", 1, 10, 32'h100);
        chk("full.ready_back", 32'(lsu_ready), 1);
        tick();
        lsu_valid = 0;
        for (int i = 1; i < 5; i++) begin
            chk_wr("full.drain", 1, 4'(10 + i), 32'(32'h100 + i));
            tick();
        end
        chk("full.idle", 32'(we), 0);

        // x0 handling: ALU and LSU results to x0 are consumed without writing
        issue_valid = 1; issue_long = 1; issue_rd = 3;
        alu_valid = 1; alu_rd = 0; alu_data = 32'hBAD0;
        tick();
        issue_rd = 0;
        alu_valid = 0;
        chk("x0.alu_we", 32'(we), 0);
        chk("x0.busy3", 32'(busy), 32'h0008);
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hBAD1;
        tick();
        issue_valid = 0; issue_long = 0;
        chk("x0.busy_issue0", 32'(busy), 32'h0008);
        lsu_rd = 3; lsu_data = 32'h333;
        tick();
        lsu_valid = 0;
        chk("x0.lsu_we", 32'(we), 0);
        chk("x0.busy_after_pop0", 32'(busy), 32'h0008);
        tick();
        chk_wr("x0.x3", 1, 3, 32'h333);
        chk("x0.busy_clr", 32'(busy), 0);
        tick();
        chk("x0.idle", 32'(we), 0);

        // Reset mid-operation: two queued LSU results and a busy bit are discarded
        issue_valid = 1; issue_long = 1; issue_rd = 4;
        alu_valid = 1; alu_rd = 2; alu_data = 32'h22;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44;
        tick();
        issue_valid = 0; issue_long = 0; issue_rd = 0;
        lsu_rd = 5; lsu_data = 32'h55;
        tick();
        lsu_valid = 0;
        chk_wr("mid.alu", 1, 2, 32'h22);
        chk("mid.busy_pre", 32'(busy), 32'h0010);
        #2 rst = 1'b1;
        #1;
        chk("mid.we", 32'(we), 0);
        chk("mid.rd", 32'(rd), 0);
        chk("mid.data", rd_data, 0);
        chk("mid.busy", 32'(busy), 0);
        chk("mid.ready", 32'(lsu_ready), 0);
        alu_valid = 0;
        tick();
        rst = 1'b0;
        #1 chk("mid.ready_after", 32'(lsu_ready), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid.no_write", 32'(we), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
